// File: rtl/vga_ctrl.sv
// vga_ctrl: VGA timing generator driven by a clock-enable pixel tick, with aligned registered hs/vs/rgb
module vga_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] pixel,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hs,
  output logic        vs,
  output logic [11:0] rgb
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  logic [DW-1:0] div_cnt;
  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic          pix_en;
  logic          active;
  always_comb begin
    pix_en = div_cnt == DIV_LAST;
    active = h_cnt < H_ACT && v_cnt < V_ACT;
    pix_x  = active ? h_cnt : '0;
    pix_y  = active ? v_cnt : '0;
  end
  // outputs are computed from the pre-advance counters so rgb lags pix_x/pix_y by one tick
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      hs      <= 1'b1;
      vs      <= 1'b1;
      rgb     <= '0;
    end else begin
      div_cnt <= pix_en ? '0 : div_cnt + 1'b1;
      if (pix_en) begin
        h_cnt <= h_cnt == H_LAST ? '0 : h_cnt + 1'b1;
        if (h_cnt == H_LAST) v_cnt <= v_cnt == V_LAST ? '0 : v_cnt + 1'b1;
        rgb <= active ? pixel : 12'h000;
        hs  <= !(h_cnt >= HS_BEG && h_cnt < HS_END);
        vs  <= !(v_cnt >= VS_BEG && v_cnt < VS_END);
      end
    end
  end
endmodule

// File: tb/tb_vga_ctrl.sv
// tb_vga_ctrl: scoreboard bench for vga_ctrl on a shrunken raster so whole frames fit in a short run
module tb_vga_ctrl;
  localparam int CD = 4, HA = 16, HF = 4, HS = 8, HB = 4, VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB, FRAME = HT * VT * CD;
  logic clk = 0, rst = 1, pmode = 0, tk;
  logic [11:0] pconst = 0, pixel, rgb;
  logic [9:0] pix_x, pix_y;
  logic hs, vs;
  logic [13:0] sb[$];
  logic [13:0] e;
  int m_div = 0, m_h = 0, m_v = 0, errs = 0, checks = 0, clk_n = 0;
  always #5 clk = ~clk;
  assign pixel = pmode ? {2'b0, pix_x} : pconst;
  vga_ctrl #(.CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
             .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
    .clk(clk), .rst(rst), .pixel(pixel), .pix_x(pix_x), .pix_y(pix_y),
    .hs(hs), .vs(vs), .rgb(rgb));
  function automatic logic act();
    return m_h < HA && m_v < VA;
  endfunction
  function automatic logic [9:0] ex_x();
    return act() ? 10'(m_h) : 10'd0;
  endfunction
  function automatic logic [9:0] ex_y();
    return act() ? 10'(m_v) : 10'd0;
  endfunction
  task automatic cyc();
    tk = !rst && m_div == CD - 1;
    if (tk) sb.push_back({!(m_h >= HA + HF && m_h < HA + HF + HS), !(m_v >= VA + VF && m_v < VA + VF + VS),
                          act() ? (pmode ? {2'b0, 10'(m_h)} : pconst) : 12'h000});
    @(posedge clk); #1; clk_n++;
    if (rst) begin
      m_div = 0; m_h = 0; m_v = 0;
    end else if (m_div == CD - 1) begin
      m_div = 0;
      if (m_h == HT - 1) begin m_h = 0; m_v = (m_v == VT - 1) ? 0 : m_v + 1; end
      else m_h++;
    end else m_div++;
  endtask
  task automatic test_reset();
    rst = 1; pmode = 0; pconst = 12'hF00;
    cyc();
    checks++;
    if ({hs, vs, rgb, pix_x, pix_y} !== {1'b1, 1'b1, 12'h0, 10'h0, 10'h0}) begin
      errs++; $display("FAIL reset_state hs/vs/rgb/x/y=%b/%b/%h/%0d/%0d exp=1/1/000/0/0", hs, vs, rgb, pix_x, pix_y);
    end
    rst = 0;
    for (int i = 0; i < 10 * CD; i++) begin
      cyc();
      checks++;
      if (pix_x !== ex_x() || pix_y !== ex_y()) begin errs++; $display("FAIL reset_xy pix=%0d,%0d exp=%0d,%0d", pix_x, pix_y, ex_x(), ex_y()); end
      if (tk) begin
        e = sb.pop_front(); checks++;
        if ({hs, vs, rgb} !== e) begin errs++; $display("FAIL reset_out hs/vs/rgb=%b/%b/%h exp=%b/%b/%h", hs, vs, rgb, e[13], e[12], e[11:0]); end
      end
    end
    checks++;
    if (pix_x !== 10'd10) begin errs++; $display("FAIL reset_rate pix_x=%0d exp=10", pix_x); end
  endtask
  task automatic test_line();
    int low = 0, fall_h = -1;
    logic phs;
    pconst = 12'h5A5;
    for (int i = 0; i < FRAME && !(m_h == 0 && m_div == 0); i++) begin cyc(); sb.delete(); end
    for (int i = 0; i < HT * CD; i++) begin
      phs = hs;
      cyc();
      if (!hs) low++;
      if (phs && !hs) fall_h = m_h;
      checks++;
      if (pix_x !== ex_x() || pix_y !== ex_y()) begin errs++; $display("FAIL line_xy pix=%0d,%0d exp=%0d,%0d", pix_x, pix_y, ex_x(), ex_y()); end
      if (tk) begin
        e = sb.pop_front(); checks++;
        if ({hs, vs, rgb} !== e) begin errs++; $display("FAIL line_out hs/vs/rgb=%b/%b/%h exp=%b/%b/%h", hs, vs, rgb, e[13], e[12], e[11:0]); end
      end
    end
    checks++;
    if (low != HS * CD) begin errs++; $display("FAIL line_hs_width clk=%0d exp=%0d", low, HS * CD); end
    checks++;
    if (fall_h != HA + HF + 1) begin errs++; $display("FAIL line_hs_start h=%0d exp=%0d", fall_h, HA + HF + 1); end
  endtask
  task automatic test_pixel_fn();
    pmode = 1;
    for (int i = 0; i < FRAME && !(m_h == 0 && m_div == 0 && m_v < VA - 1); i++) begin cyc(); sb.delete(); end
    for (int i = 0; i < 2 * HT * CD; i++) begin
      cyc();
      checks++;
      if (pix_x !== ex_x() || pix_y !== ex_y()) begin errs++; $display("FAIL pixfn_xy pix=%0d,%0d exp=%0d,%0d", pix_x, pix_y, ex_x(), ex_y()); end
      if (tk) begin
        e = sb.pop_front(); checks++;
        if ({hs, vs, rgb} !== e) begin errs++; $display("FAIL pixfn_out hs/vs/rgb=%b/%b/%h exp=%b/%b/%h", hs, vs, rgb, e[13], e[12], e[11:0]); end
      end
    end
    pmode = 0;
  endtask
  task automatic test_wrap();
    pconst = 12'hABC;
    for (int i = 0; i < FRAME + 8 && !(m_h == HT - 1 && m_v == VT - 1 && m_div == CD - 1); i++) begin cyc(); sb.delete(); end
    cyc();
    checks++;
    if ({pix_x, pix_y, rgb} !== 32'h0) begin errs++; $display("FAIL wrap_zero x/y/rgb=%0d/%0d/%h exp=0/0/000", pix_x, pix_y, rgb); end
    if (tk) begin
      e = sb.pop_front(); checks++;
      if ({hs, vs, rgb} !== e) begin errs++; $display("FAIL wrap_out hs/vs/rgb=%b/%b/%h exp=%b/%b/%h", hs, vs, rgb, e[13], e[12], e[11:0]); end
    end
    for (int i = 0; i < CD; i++) begin
      cyc();
      if (tk) begin
        e = sb.pop_front(); checks++;
        if (rgb !== 12'hABC || {hs, vs, rgb} !== e) begin errs++; $display("FAIL wrap_rgb rgb=%h exp=abc", rgb); end
      end
    end
  endtask
  task automatic test_mid_reset();
    int n = 0;
    pconst = 12'h123;
    for (int i = 0; i < FRAME + 8 && !(m_v == VA + VF && m_h == HA + HF + 4 && m_div == 0); i++) begin cyc(); sb.delete(); end
    checks++;
    if ({hs, vs} !== 2'b00) begin errs++; $display("FAIL midrst_pre hs/vs=%b/%b exp=0/0", hs, vs); end
    rst = 1;
    cyc();
    rst = 0;
    checks++;
    if ({hs, vs, rgb, pix_x, pix_y} !== {1'b1, 1'b1, 12'h0, 10'h0, 10'h0}) begin
      errs++; $display("FAIL midrst_state hs/vs/rgb/x/y=%b/%b/%h/%0d/%0d exp=1/1/000/0/0", hs, vs, rgb, pix_x, pix_y);
    end
    while (pix_x === 10'd0 && n < 4 * CD) begin
      cyc(); n++;
      if (tk) begin
        e = sb.pop_front(); checks++;
        if ({hs, vs, rgb} !== e) begin errs++; $display("FAIL midrst_out hs/vs/rgb=%b/%b/%h exp=%b/%b/%h", hs, vs, rgb, e[13], e[12], e[11:0]); end
      end
    end
    checks++;
    if (n != CD) begin errs++; $display("FAIL midrst_first_tick clk=%0d exp=%0d", n, CD); end
    for (int i = 0; i < 3 * CD; i++) begin
      cyc();
      checks++;
      if (pix_x !== ex_x() || pix_y !== ex_y()) begin errs++; $display("FAIL midrst_xy pix=%0d,%0d exp=%0d,%0d", pix_x, pix_y, ex_x(), ex_y()); end
      if (tk) begin
        e = sb.pop_front(); checks++;
        if ({hs, vs, rgb} !== e) begin errs++; $display("FAIL midrst_run hs/vs/rgb=%b/%b/%h exp=%b/%b/%h", hs, vs, rgb, e[13], e[12], e[11:0]); end
      end
    end
  endtask
  task automatic test_frame();
    int low = 0, nf = 0, f0 = 0, f1 = 0, fv = -1, fh = -1;
    logic pvs;
    pconst = 12'h0F0;
    for (int i = 0; i < FRAME + 8 && !(m_h == 0 && m_v == 0 && m_div == 0); i++) begin cyc(); sb.delete(); end
    for (int i = 0; i < 2 * FRAME; i++) begin
      pvs = vs;
      cyc();
      if (!vs) low++;
      if (pvs && !vs) begin
        if (nf == 0) begin f0 = clk_n; fv = m_v; fh = m_h; end else f1 = clk_n;
        nf++;
      end
      checks++;
      if (pix_x !== ex_x() || pix_y !== ex_y()) begin errs++; $display("FAIL frame_xy pix=%0d,%0d exp=%0d,%0d", pix_x, pix_y, ex_x(), ex_y()); end
      if (tk) begin
        e = sb.pop_front(); checks++;
        if ({hs, vs, rgb} !== e) begin errs++; $display("FAIL frame_out hs/vs/rgb=%b/%b/%h exp=%b/%b/%h", hs, vs, rgb, e[13], e[12], e[11:0]); end
      end
    end
    checks++;
    if (low != 2 * VS * HT * CD) begin errs++; $display("FAIL frame_vs_width clk=%0d exp=%0d", low, 2 * VS * HT * CD); end
    checks++;
    if (nf != 2 || f1 - f0 != FRAME) begin errs++; $display("FAIL frame_period falls=%0d period=%0d exp=2/%0d", nf, f1 - f0, FRAME); end
    checks++;
    if (fv != VA + VF || fh != 1) begin errs++; $display("FAIL frame_vs_start v/h=%0d/%0d exp=%0d/1", fv, fh, VA + VF); end
  endtask
  initial begin
    test_reset();
    test_line();
    test_pixel_fn();
    test_wrap();
    test_mid_reset();
    test_frame();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
